// File: rtl/maj_bist_pkg.sv
// Shared types and constants for the majority-netlist BIST engine.
package maj_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } maj_bist_state_t;

  localparam int unsigned MAJ_N_MIN = 3;
  localparam int unsigned MAJ_N_MAX = 31;
  // Popcount width wide enough for the largest supported N.
  localparam int unsigned MAJ_CNT_W = $clog2(MAJ_N_MAX + 1);

  function automatic int unsigned maj_threshold(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/maj_bist_engine_if.sv
// Harness-side bundle of the BIST engine: sweep control, DUT stimulus/response and results.
// MAJ_BIST_FAILLOG_EN adds the first-failing-vector capture signals.
interface maj_bist_engine_if #(
  parameter int unsigned N     = 25,
  parameter int unsigned ERR_W = 16
) ();
  logic             start;
  logic [N-1:0]     stim;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;

`ifdef MAJ_BIST_FAILLOG_EN
  logic             first_fail_valid;
  logic [N-1:0]     first_fail_vec;

  modport master (
    output start, dut_y,
    input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );
  modport slave (
    input  start, dut_y,
    output stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );
`else
  modport master (
    output start, dut_y,
    input  stim, busy, done, pass, err_count
  );
  modport slave (
    input  start, dut_y,
    output stim, busy, done, pass, err_count
  );
`endif
endinterface

// File: rtl/maj_ref_popcount.sv
// Reference majority: popcount of the vector compared against the (N+1)/2 threshold.
module maj_ref_popcount
  import maj_bist_pkg::*;
#(
  parameter int unsigned N = 25
) (
  input  logic [N-1:0] vec_i,
  output logic         exp
);
  logic [MAJ_CNT_W-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + MAJ_CNT_W'(vec_i[i]);
    end
    exp = (cnt >= MAJ_CNT_W'(maj_threshold(N)));
  end
endmodule

// File: rtl/maj_bist_engine.sv
// Exhaustive sweep generator and majority response checker for an N-input DUT.
// MAJ_BIST_FAILLOG_EN enables capture of the first mismatching vector.
module maj_bist_engine
  import maj_bist_pkg::*;
#(
  parameter int unsigned N       = 25,
  parameter int unsigned DUT_LAT = 0,
  parameter int unsigned ERR_W   = 16
) (
  input logic              clk,
  input logic              rst,
  maj_bist_engine_if.slave bus
);
  localparam int unsigned    DW         = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam logic [DW-1:0]  DRAIN_LAST = DW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  maj_bist_state_t  state_q, state_d;
  logic [N-1:0]     stim_q, stim_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             sweep_start;
  logic             exp_now, vld_now;
  logic             exp_cmp, vld_cmp;
  logic             cmp_fail;
`ifdef MAJ_BIST_FAILLOG_EN
  logic [N-1:0]     vec_cmp;
`endif

  maj_ref_popcount #(.N(N)) u_ref (
    .vec_i (stim_q),
    .exp   (exp_now)
  );

  assign vld_now = (state_q == RUN);

  // Expected bit (and valid) travel alongside the DUT pipeline so they line up with dut_y.
  generate
    if (DUT_LAT == 0) begin : g_no_lat
      assign exp_cmp = exp_now;
      assign vld_cmp = vld_now;
`ifdef MAJ_BIST_FAILLOG_EN
      assign vec_cmp = stim_q;
`endif
    end else begin : g_lat
      logic [DUT_LAT-1:0] exp_dl_q;
      logic [DUT_LAT-1:0] vld_dl_q;
`ifdef MAJ_BIST_FAILLOG_EN
      logic [N-1:0]       vec_dl_q [DUT_LAT];
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          exp_dl_q <= '0;
          vld_dl_q <= '0;
`ifdef MAJ_BIST_FAILLOG_EN
          for (int unsigned i = 0; i < DUT_LAT; i++) vec_dl_q[i] <= '0;
`endif
        end else begin
          exp_dl_q[0] <= exp_now;
          vld_dl_q[0] <= vld_now;
`ifdef MAJ_BIST_FAILLOG_EN
          vec_dl_q[0] <= stim_q;
`endif
          for (int unsigned i = 1; i < DUT_LAT; i++) begin
            exp_dl_q[i] <= exp_dl_q[i-1];
            vld_dl_q[i] <= vld_dl_q[i-1];
`ifdef MAJ_BIST_FAILLOG_EN
            vec_dl_q[i] <= vec_dl_q[i-1];
`endif
          end
        end
      end
      assign exp_cmp = exp_dl_q[DUT_LAT-1];
      assign vld_cmp = vld_dl_q[DUT_LAT-1];
`ifdef MAJ_BIST_FAILLOG_EN
      assign vec_cmp = vec_dl_q[DUT_LAT-1];
`endif
    end
  endgenerate

  assign cmp_fail = vld_cmp && (bus.dut_y != exp_cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      drain_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    drain_d     = drain_q;
    err_d       = err_q;
    sweep_start = 1'b0;
    if (cmp_fail && (err_q != '1)) err_d = err_q + 1'b1;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          stim_d      = '0;
          err_d       = '0;
          sweep_start = 1'b1;
        end
      end
      RUN: begin
        // Terminal vector wraps stim back to 0 and leaves RUN, so no vector repeats.
        stim_d = stim_q + 1'b1;
        if (stim_q == '1) begin
          state_d = (DUT_LAT == 0) ? DONE : DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stim      = stim_q;
  assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (err_q == '0);
  assign bus.err_count = err_q;

`ifdef MAJ_BIST_FAILLOG_EN
  logic         ff_vld_q;
  logic [N-1:0] ff_vec_q;

  always_ff @(posedge clk) begin
    if (rst || sweep_start) begin
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
    end else if (cmp_fail && !ff_vld_q) begin
      ff_vld_q <= 1'b1;
      ff_vec_q <= vec_cmp;
    end
  end

  assign bus.first_fail_valid = ff_vld_q;
  assign bus.first_fail_vec   = ff_vec_q;
`endif
endmodule

// File: tb/tb_maj_bist_engine.sv
// Self-checking bench: two engine instances (combinational DUT, and 2-stage DUT with 3-bit counter).
module tb_maj_bist_engine;
  localparam int unsigned N  = 5;
  localparam int          NV = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maj_bist_engine_if #(.N(5), .ERR_W(16)) ifA ();
  maj_bist_engine_if #(.N(5), .ERR_W(3))  ifB ();

  maj_bist_engine #(.N(5), .DUT_LAT(0), .ERR_W(16)) uA (.clk(clk), .rst(rst), .bus(ifA.slave));
  maj_bist_engine #(.N(5), .DUT_LAT(2), .ERR_W(3))  uB (.clk(clk), .rst(rst), .bus(ifB.slave));

  // DUT behaviour codes: 0 ideal, 1 tied 0, 2 tied 1, 3 masked faults (A), 4 one-stage pipeline (B)
  int          modeA, modeB;
  logic [31:0] fault_mask;
  logic        p1, p2;

  int tests    = 0;
  int failures = 0;

  function automatic logic maj_of(input int unsigned v);
    return $countones(v) >= (N + 1) / 2;
  endfunction

  always_comb begin
    ifA.dut_y = maj_of(32'(ifA.stim));
    case (modeA)
      1:       ifA.dut_y = 1'b0;
      2:       ifA.dut_y = 1'b1;
      3:       ifA.dut_y = maj_of(32'(ifA.stim)) ^ fault_mask[ifA.stim];
      default: ;
    endcase
  end

  always @(posedge clk) begin
    p1 <= maj_of(32'(ifB.stim));
    p2 <= p1;
  end

  always_comb begin
    ifB.dut_y = p2;
    case (modeB)
      1:       ifB.dut_y = 1'b0;
      2:       ifB.dut_y = 1'b1;
      4:       ifB.dut_y = p1;
      default: ;
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? ifA.busy : ifB.busy;
  endfunction
  function automatic logic get_done(input int inst);
    return (inst == 0) ? ifA.done : ifB.done;
  endfunction
  function automatic logic get_pass(input int inst);
    return (inst == 0) ? ifA.pass : ifB.pass;
  endfunction
  function automatic int get_err(input int inst);
    return (inst == 0) ? int'(ifA.err_count) : int'(ifB.err_count);
  endfunction
  function automatic int get_stim(input int inst);
    return (inst == 0) ? int'(ifA.stim) : int'(ifB.stim);
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) ifA.start = v;
    else           ifB.start = v;
  endtask

  // Reference sweep: evaluate every vector directly from the majority rule.
  function automatic void ref_sweep(input int mode, input logic [31:0] mask, input int errw,
                                    output int errs, output int first);
    int   raw;
    logic want, got;
    raw   = 0;
    first = -1;
    for (int v = 0; v < NV; v++) begin
      want = maj_of(v);
      case (mode)
        1:       got = 1'b0;
        2:       got = 1'b1;
        3:       got = want ^ mask[v];
        default: got = want;
      endcase
      if (got != want) begin
        raw++;
        if (first < 0) first = v;
      end
    end
    errs = (raw > (1 << errw) - 1) ? (1 << errw) - 1 : raw;
  endfunction

  task automatic run_sweep(input int inst, input int restart_at, input int exp_len);
    int len, stim_bad;
    @(negedge clk) set_start(inst, 1'b1);
    @(negedge clk) set_start(inst, 1'b0);
    check("start_busy", get_busy(inst), 1);
    check("start_done_clr", get_done(inst), 0);
    check("start_err_clr", get_err(inst), 0);
    check("start_stim0", get_stim(inst), 0);
    len      = 0;
    stim_bad = 0;
    while (get_busy(inst) && len < 200) begin
      if (get_stim(inst) != ((len < NV) ? len : 0)) stim_bad++;
      set_start(inst, (len == restart_at));
      len++;
      @(negedge clk);
    end
    set_start(inst, 1'b0);
    check("sweep_len", len, exp_len);
    check("stim_seq_errs", stim_bad, 0);
    check("done_rise", get_done(inst), 1);
  endtask

  typedef struct {
    int   inst;
    int   mode;
    int   restart_at;
    int   exp_len;
    int   exp_err;
    logic exp_pass;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int errs, first, n, cnt;
    tbl[0] = '{0, 0, -1, 32, 0, 1'b1};
    tbl[1] = '{0, 1, -1, 32, 16, 1'b0};
    tbl[2] = '{0, 2, -1, 32, 16, 1'b0};
    tbl[3] = '{0, 0, 10, 32, 0, 1'b1};
    tbl[4] = '{1, 0, -1, 34, 0, 1'b1};
    tbl[5] = '{1, 2, -1, 34, 7, 1'b0};
    tbl[6] = '{1, 1, 3, 34, 7, 1'b0};
    tbl[7] = '{1, 0, 20, 34, 0, 1'b1};

    rst        = 1'b1;
    modeA      = 0;
    modeB      = 0;
    fault_mask = '0;
    ifA.start  = 1'b0;
    ifB.start  = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", get_busy(i), 0);
      check("rst_done", get_done(i), 0);
      check("rst_pass", get_pass(i), 0);
      check("rst_err", get_err(i), 0);
      check("rst_stim", get_stim(i), 0);
    end
    rst = 1'b0;

    foreach (tbl[k]) begin
      if (tbl[k].inst == 0) modeA = tbl[k].mode;
      else                  modeB = tbl[k].mode;
      run_sweep(tbl[k].inst, tbl[k].restart_at, tbl[k].exp_len);
      check("tbl_err", get_err(tbl[k].inst), tbl[k].exp_err);
      check("tbl_pass", get_pass(tbl[k].inst), tbl[k].exp_pass);
`ifdef MAJ_BIST_FAILLOG_EN
      if (tbl[k].inst == 0) begin
        ref_sweep(tbl[k].mode, '0, 16, errs, first);
        check("tbl_ff_valid", ifA.first_fail_valid, errs > 0);
        if (errs > 0) check("tbl_ff_vec", ifA.first_fail_vec, first);
      end
`endif
      repeat (3) @(negedge clk);
      check("done_held", get_done(tbl[k].inst), 1);
      check("err_held", get_err(tbl[k].inst), tbl[k].exp_err);
    end

    // DUT one stage shorter than the engine's delay line must be flagged.
    modeB = 4;
    run_sweep(1, -1, 34);
    check("short_lat_err_nonzero", get_err(1) != 0, 1);
    check("short_lat_pass", get_pass(1), 0);
    modeB = 0;

    // Reset abandons a sweep in progress.
    modeA = 1;
    @(negedge clk) ifA.start = 1'b1;
    @(negedge clk) ifA.start = 1'b0;
    n = 0;
    while (ifA.stim != 5'd10 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("rst_reach_stim10", ifA.stim, 10);
    cnt = 0;
    for (int v = 0; v < 10; v++) if (maj_of(v)) cnt++;
    check("err_before_rst", ifA.err_count, cnt);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", ifA.busy, 0);
    check("midrst_stim", ifA.stim, 0);
    check("midrst_err", ifA.err_count, 0);
    check("midrst_done", ifA.done, 0);
    rst   = 1'b0;
    modeA = 0;
    run_sweep(0, -1, 32);
    check("post_rst_pass", ifA.pass, 1);

    // Randomised fault patterns against the reference sweep.
    modeA = 3;
    for (int it = 0; it < 8; it++) begin
      fault_mask = $urandom;
      if (it % 2 == 0) fault_mask = fault_mask & $urandom & $urandom;
      if (it == 7) fault_mask = '0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ref_sweep(3, fault_mask, 16, errs, first);
      run_sweep(0, -1, 32);
      check("rand_err", ifA.err_count, errs);
      check("rand_pass", ifA.pass, errs == 0);
`ifdef MAJ_BIST_FAILLOG_EN
      check("rand_ff_valid", ifA.first_fail_valid, errs > 0);
      if (errs > 0) check("rand_ff_vec", ifA.first_fail_vec, first);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end
endmodule
